// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM controller: FSM states, wait-counter width, lane helper.
// The optional parity feature is selected with the SRAM_PARITY_EN macro in the consumers.
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int unsigned CNT_W = 4;

    function automatic int unsigned lanes(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/sram_array.sv
// Word storage with byte-lane writes and a registered read port; unreset contents.
// With SRAM_PARITY_EN each byte carries an even-parity bit checked on reads.
module sram_array
    import sram_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 2048,
    parameter int unsigned IDX_W  = 11
) (
    input  logic                      clk,
    input  logic                      en,
    input  logic                      we,
    input  logic [IDX_W-1:0]          addr,
    input  logic [DATA_W-1:0]         wdata,
    input  logic [lanes(DATA_W)-1:0]  be,
`ifdef SRAM_PARITY_EN
    input  logic                      par_inj,
    output logic                      perr,
`endif
    output logic [DATA_W-1:0]         rdata
);

    localparam int unsigned NB = lanes(DATA_W);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < NB; i++) begin
                    if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

`ifdef SRAM_PARITY_EN
    logic [NB-1:0] par [DEPTH];
    logic [NB-1:0] rd_par_c;

    // Parity recomputed from the word being read
    always_comb begin
        rd_par_c = '0;
        for (int i = 0; i < NB; i++) rd_par_c[i] = ^mem[addr][8*i +: 8];
    end

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < NB; i++) begin
                    if (be[i]) par[addr][i] <= (^wdata[8*i +: 8]) ^ par_inj;
                end
            end else begin
                perr <= |(rd_par_c ^ par[addr]);
            end
        end
    end
`endif

endmodule

// File: rtl/sram_ctrl.sv
// SRAM controller: req/ready handshake, MAR/MDR staging, wait states, range check.
// Define SRAM_PARITY_EN to add per-byte parity with the perr and par_inj ports.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 11,
    parameter int unsigned DEPTH       = 2048,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                      clk,
    input  logic                      nReset,
    input  logic                      req,
    input  logic                      we,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [DATA_W-1:0]         wdata,
    input  logic [lanes(DATA_W)-1:0]  be,
`ifdef SRAM_PARITY_EN
    input  logic                      par_inj,
    output logic                      perr,
`endif
    output logic                      ready,
    output logic                      ack,
    output logic [DATA_W-1:0]         rdata,
    output logic                      err
);

    localparam int unsigned   NB      = lanes(DATA_W);
    localparam int unsigned   IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] WS_L  = CNT_W'(WAIT_STATES);

    state_t              state, next_state;
    logic [ADDR_W-1:0]   mar;
    logic [DATA_W-1:0]   mdr;
    logic [NB-1:0]       be_q;
    logic                we_q;
    logic [CNT_W-1:0]    cnt;
    logic                accept_c, oor_c, arr_en_c;
    logic [DATA_W-1:0]   arr_rdata, rd_word_c;
`ifdef SRAM_PARITY_EN
    logic                inj_q, arr_perr;
`endif

    assign accept_c  = (state == IDLE) && ready && req;
    // Unsigned compare, one bit wider so DEPTH == 2**ADDR_W is representable
    assign oor_c     = ({1'b0, mar} >= DEPTH_L);
    assign arr_en_c  = (state == ACCESS) && !oor_c;
    assign rd_word_c = oor_c ? '0 : arr_rdata;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept_c) next_state = (WS_L == '0) ? ACCESS : WAIT;
            WAIT:    if (cnt <= CNT_W'(1)) next_state = ACCESS;
            ACCESS:  next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request staging and registered response outputs
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            mar   <= '0;
            mdr   <= '0;
            be_q  <= '0;
            we_q  <= 1'b0;
            cnt   <= '0;
            ready <= 1'b0;
            ack   <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
`ifdef SRAM_PARITY_EN
            inj_q <= 1'b0;
            perr  <= 1'b0;
`endif
        end else begin
            ready <= (next_state == IDLE);
            ack   <= 1'b0;
            err   <= 1'b0;
`ifdef SRAM_PARITY_EN
            perr  <= 1'b0;
`endif
            if (accept_c) begin
                mar  <= addr;
                mdr  <= wdata;
                we_q <= we;
                be_q <= be;
                cnt  <= WS_L;
`ifdef SRAM_PARITY_EN
                inj_q <= par_inj;
`endif
            end
            if (state == WAIT) cnt <= cnt - CNT_W'(1);
            if (state == RESP) begin
                ack <= 1'b1;
                err <= oor_c;
                if (!we_q) begin
                    mdr   <= rd_word_c;
                    rdata <= rd_word_c;
`ifdef SRAM_PARITY_EN
                    perr  <= arr_perr & ~oor_c;
`endif
                end
            end
        end
    end

    sram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk     (clk),
        .en      (arr_en_c),
        .we      (we_q),
        .addr    (mar[IDX_W-1:0]),
        .wdata   (mdr),
        .be      (be_q),
`ifdef SRAM_PARITY_EN
        .par_inj (inj_q),
        .perr    (arr_perr),
`endif
        .rdata   (arr_rdata)
    );

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: reset abort, byte lanes, range check, timing, optional parity.
module tb_sram_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        nReset, req, we, par_inj;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ready, ack, err, perr;
    logic [31:0] rdata;

    logic        req0, ready0, ack0, err0, perr0;
    logic [31:0] rdata0;
    logic        req3, ready3, ack3, err3, perr3;
    logic [31:0] rdata3;

    int checks = 0;
    int errors = 0;

    sram_ctrl #(.DATA_W(32), .ADDR_W(11), .DEPTH(1000), .WAIT_STATES(1)) dut (
        .clk(clk), .nReset(nReset), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
`ifdef SRAM_PARITY_EN
        .par_inj(par_inj), .perr(perr),
`endif
        .ready(ready), .ack(ack), .rdata(rdata), .err(err)
    );

    sram_ctrl #(.DATA_W(32), .ADDR_W(11), .DEPTH(2048), .WAIT_STATES(0)) dut_ws0 (
        .clk(clk), .nReset(nReset), .req(req0), .we(1'b0), .addr(11'h000), .wdata(32'h0), .be(4'h0),
`ifdef SRAM_PARITY_EN
        .par_inj(1'b0), .perr(perr0),
`endif
        .ready(ready0), .ack(ack0), .rdata(rdata0), .err(err0)
    );

    sram_ctrl #(.DATA_W(32), .ADDR_W(11), .DEPTH(2048), .WAIT_STATES(3)) dut_ws3 (
        .clk(clk), .nReset(nReset), .req(req3), .we(1'b0), .addr(11'h000), .wdata(32'h0), .be(4'h0),
`ifdef SRAM_PARITY_EN
        .par_inj(1'b0), .perr(perr3),
`endif
        .ready(ready3), .ack(ack3), .rdata(rdata3), .err(err3)
    );

`ifndef SRAM_PARITY_EN
    assign perr  = 1'b0;
    assign perr0 = 1'b0;
    assign perr3 = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic [10:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check("ready_timeout", 32'(ready), 32'd1);
    endtask

    // One complete access; returns response fields and edges from accept to ack
    task automatic do_access(input logic w, input logic [10:0] a, input logic [31:0] d,
                             input logic [3:0] b, input logic inj,
                             output logic [31:0] rd, output logic e, output logic pe,
                             output int lat);
        wait_ready();
        req = 1'b1; we = w; addr = a; wdata = d; be = b; par_inj = inj;
        @(posedge clk);
        #1 req = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!ack && lat < 40);
        if (!ack) check("ack_timeout", 32'(ack), 32'd1);
        rd = rdata; e = err; pe = perr;
    endtask

    logic [31:0] rd, last_rd;
    logic        e, pe;
    int          lat, ack_cnt;
    int          t0[$], t3[$];

    initial begin
        vecs[0]  = '{1'b1, 11'h005, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 11'h005, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 11'h005, 32'h11223344, 4'h5, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 11'h005, 32'h0,        4'h0, 32'hDE22BE44, 1'b0};
        vecs[4]  = '{1'b1, 11'h005, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
        vecs[5]  = '{1'b0, 11'h005, 32'h0,        4'hF, 32'hDE22BE44, 1'b0};
        vecs[6]  = '{1'b1, 11'd999, 32'h0BADCAFE, 4'hF, 32'h0,        1'b0};
        vecs[7]  = '{1'b1, 11'd1000,32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
        vecs[8]  = '{1'b0, 11'd1000,32'h0,        4'h0, 32'h0,        1'b1};
        vecs[9]  = '{1'b0, 11'd999, 32'h0,        4'h0, 32'h0BADCAFE, 1'b0};
        vecs[10] = '{1'b1, 11'h405, 32'hAAAAAAAA, 4'hF, 32'h0,        1'b1};
        vecs[11] = '{1'b0, 11'h005, 32'h0,        4'h0, 32'hDE22BE44, 1'b0};
        vecs[12] = '{1'b0, 11'h7FF, 32'h0,        4'h0, 32'h0,        1'b1};
        vecs[13] = '{1'b0, 11'd999, 32'h0,        4'h0, 32'h0BADCAFE, 1'b0};

        nReset = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0; par_inj = 1'b0;
        req0 = 1'b0; req3 = 1'b0;
        #12;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_ack",   32'(ack),   32'd0);
        check("rst_err",   32'(err),   32'd0);
        check("rst_rdata", rdata,      32'h0);
        @(negedge clk);
        @(negedge clk) nReset = 1'b1;

        // Reset during WAIT of a write aborts it without ack
        do_access(1'b1, 11'h010, 32'hCAFEF00D, 4'hF, 1'b0, rd, e, pe, lat);
        do_access(1'b0, 11'h010, 32'h0, 4'h0, 1'b0, rd, e, pe, lat);
        check("pre_rst_read", rd, 32'hCAFEF00D);
        wait_ready();
        req = 1'b1; we = 1'b1; addr = 11'h010; wdata = 32'h12345678; be = 4'hF;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk) nReset = 1'b0;
        #1;
        check("midrst_ready", 32'(ready), 32'd0);
        check("midrst_rdata", rdata,      32'h0);
        ack_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 2) nReset = 1'b1;
            if (ack) ack_cnt++;
        end
        check("midrst_no_ack", 32'(ack_cnt), 32'd0);
        do_access(1'b0, 11'h010, 32'h0, 4'h0, 1'b0, rd, e, pe, lat);
        check("midrst_old_data", rd, 32'hCAFEF00D);
        last_rd = 32'hCAFEF00D;

        for (int i = 0; i < NV; i++) begin
            do_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, 1'b0, rd, e, pe, lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
            check($sformatf("v%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
            if (!vecs[i].we) last_rd = vecs[i].exp_rd;
            check($sformatf("v%0d_rdata", i), rd, last_rd);
        end

        // A req pulse while busy is dropped
        wait_ready();
        req = 1'b1; we = 1'b1; addr = 11'h030; wdata = 32'h00000055; be = 4'hF;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        req = 1'b1; wdata = 32'h000000AA;
        @(negedge clk) req = 1'b0;
        ack_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ack) ack_cnt++;
        end
        check("busy_one_ack", 32'(ack_cnt), 32'd1);
        do_access(1'b0, 11'h030, 32'h0, 4'h0, 1'b0, rd, e, pe, lat);
        check("busy_dropped_data", rd, 32'h00000055);

        // Continuous req: accept spacing is WAIT_STATES+3 cycles
        @(negedge clk);
        req0 = 1'b1; req3 = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (ready0) t0.push_back(c);
            if (ready3) t3.push_back(c);
        end
        req0 = 1'b0; req3 = 1'b0;
        check("ws0_accepts", 32'(t0.size() >= 4), 32'd1);
        check("ws3_accepts", 32'(t3.size() >= 4), 32'd1);
        for (int k = 0; k < 3; k++) begin
            if (t0.size() >= 4) check($sformatf("ws0_period%0d", k), 32'(t0[k+1] - t0[k]), 32'd3);
            if (t3.size() >= 4) check($sformatf("ws3_period%0d", k), 32'(t3[k+1] - t3[k]), 32'd6);
        end

`ifdef SRAM_PARITY_EN
        do_access(1'b1, 11'h020, 32'h000000FF, 4'hF, 1'b1, rd, e, pe, lat);
        do_access(1'b0, 11'h020, 32'h0, 4'h0, 1'b0, rd, e, pe, lat);
        check("par_inj_perr", 32'(pe), 32'd1);
        check("par_inj_rdata", rd, 32'h000000FF);
        do_access(1'b1, 11'h020, 32'h000000FF, 4'hF, 1'b0, rd, e, pe, lat);
        do_access(1'b0, 11'h020, 32'h0, 4'h0, 1'b0, rd, e, pe, lat);
        check("par_clean_perr", 32'(pe), 32'd0);
        do_access(1'b0, 11'd1000, 32'h0, 4'h0, 1'b0, rd, e, pe, lat);
        check("par_oor_perr", 32'(pe), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
